// File: rtl/cbs_frame_scheduler_pkg.sv
// Shared definitions for the CBS frame scheduler: FSM states, default
// credit/slope widths and the tkeep popcount helper.
package cbs_frame_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } sched_state_t;

    localparam int unsigned CBS_CREDIT_WIDTH = 32;
    localparam int unsigned CBS_SLOPE_WIDTH  = 16;

    // Byte count of a beat; callers zero-extend tkeep to 64 bits.
    function automatic logic [7:0] cbs_popcount(input logic [63:0] v);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cbs_frame_scheduler_if.sv
// Arbiter-side bundle: per-queue pending flags, the monitored m_axis
// handshake, FIFO back-pressure and the scheduler's queue select.
interface cbs_frame_scheduler_if
    import cbs_frame_scheduler_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = 8,
    parameter int unsigned KEEP_WIDTH = 1
);
    logic                  fifo_is_almost_full;
    logic [NUM_QUEUES-1:0] q_tvalid;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic [NUM_QUEUES-1:0] grant;
    logic                  grant_valid;

    // Frame arbiter side.
    modport master (
        output fifo_is_almost_full, q_tvalid,
        output m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tkeep,
        input  grant, grant_valid
    );

    // Scheduler side.
    modport slave (
        input  fifo_is_almost_full, q_tvalid,
        input  m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tkeep,
        output grant, grant_valid
    );
endinterface

// File: rtl/cbs_frame_scheduler_credit_counter.sv
// Per-queue 802.1Qav credit: gains idle_slope every clk while active,
// pending or negative, spends byte_cost per accepted byte, and is
// clamped to [lo_credit, hi_credit] (hi first, then lo).
module cbs_frame_scheduler_credit_counter
    import cbs_frame_scheduler_pkg::*;
#(
    parameter int unsigned CREDIT_WIDTH = CBS_CREDIT_WIDTH,
    parameter int unsigned SLOPE_WIDTH  = CBS_SLOPE_WIDTH
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           shaped,
    input  logic                           active,
    input  logic                           pending,
    input  logic                           debit_en,
    input  logic [7:0]                     bytes,
    input  logic [SLOPE_WIDTH-1:0]         idle_slope,
    input  logic [SLOPE_WIDTH-1:0]         byte_cost,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    input  logic signed [CREDIT_WIDTH-1:0] lo_credit,
    output logic signed [CREDIT_WIDTH-1:0] credit
);
    localparam int unsigned WIDE = CREDIT_WIDTH + SLOPE_WIDTH + 4;

    logic signed [WIDE-1:0]         cred_ext, hi_ext, lo_ext;
    logic signed [WIDE-1:0]         gain, cost, sum, clamp_hi, clamped;
    logic signed [CREDIT_WIDTH-1:0] credit_nxt;

    // Wide, non-wrapping update and clamp; then pick update/zero/hold.
    always_comb begin
        cred_ext = {{(WIDE-CREDIT_WIDTH){credit[CREDIT_WIDTH-1]}}, credit};
        hi_ext   = {{(WIDE-CREDIT_WIDTH){hi_credit[CREDIT_WIDTH-1]}}, hi_credit};
        lo_ext   = {{(WIDE-CREDIT_WIDTH){lo_credit[CREDIT_WIDTH-1]}}, lo_credit};
        gain     = {{(WIDE-SLOPE_WIDTH){1'b0}}, idle_slope};
        cost     = '0;
        if (debit_en) begin
            cost = WIDE'(bytes) * WIDE'(byte_cost);
        end
        sum      = cred_ext + gain - cost;
        clamp_hi = (sum > hi_ext) ? hi_ext : sum;
        clamped  = (clamp_hi < lo_ext) ? lo_ext : clamp_hi;

        credit_nxt = credit;
        if (!shaped) begin
            credit_nxt = '0;
        end else if (active || pending || credit[CREDIT_WIDTH-1]) begin
            credit_nxt = clamped[CREDIT_WIDTH-1:0];
        end else if (credit != '0) begin
            // Positive credit is discarded while the queue is idle.
            credit_nxt = '0;
        end
    end

    // Credit register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credit <= '0;
        end else begin
            credit <= credit_nxt;
        end
    end
endmodule

// File: rtl/cbs_frame_scheduler.sv
// Frame-level CBS scheduler for the egress arbiter: per-queue credit,
// strict-priority grant (highest index wins) held until the accepted
// tlast beat. Optional per-queue frame statistics when the macro
// CBS_SCHED_STATS_EN is defined (adds stat_frames).
module cbs_frame_scheduler
    import cbs_frame_scheduler_pkg::*;
#(
    parameter int unsigned NUM_QUEUES   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned CREDIT_WIDTH = CBS_CREDIT_WIDTH,
    parameter int unsigned SLOPE_WIDTH  = CBS_SLOPE_WIDTH
) (
    input  logic                               clk,
    input  logic                               rstn,
    cbs_frame_scheduler_if.slave               bus,
    input  logic [NUM_QUEUES-1:0]              cfg_shaped_mask,
    input  logic [NUM_QUEUES*SLOPE_WIDTH-1:0]  cfg_idle_slope,
    input  logic [NUM_QUEUES*SLOPE_WIDTH-1:0]  cfg_byte_cost,
    input  logic [NUM_QUEUES*CREDIT_WIDTH-1:0] cfg_hi_credit,
    input  logic [NUM_QUEUES*CREDIT_WIDTH-1:0] cfg_lo_credit,
    output logic [NUM_QUEUES*CREDIT_WIDTH-1:0] credit
`ifdef CBS_SCHED_STATS_EN
    ,
    output logic [NUM_QUEUES*32-1:0]           stat_frames
`endif
);
    sched_state_t          state, state_nxt;
    logic [NUM_QUEUES-1:0] grant_q, grant_nxt, elig, sel;
    logic                  gv_q, gv_nxt;
    logic                  beat, frame_end;
    logic [7:0]            beat_bytes;

    assign beat       = bus.m_axis_tvalid & bus.m_axis_tready;
    assign frame_end  = (state == ST_TX) & beat & bus.m_axis_tlast;
    assign beat_bytes = cbs_popcount(64'(bus.m_axis_tkeep));

    assign bus.grant       = grant_q;
    assign bus.grant_valid = gv_q;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        assign elig[q] = bus.q_tvalid[q] &
                         (~cfg_shaped_mask[q] | ~credit[q*CREDIT_WIDTH + CREDIT_WIDTH - 1]);

        cbs_frame_scheduler_credit_counter #(
            .CREDIT_WIDTH (CREDIT_WIDTH),
            .SLOPE_WIDTH  (SLOPE_WIDTH)
        ) u_credit (
            .clk        (clk),
            .rstn       (rstn),
            .shaped     (cfg_shaped_mask[q]),
            .active     ((state == ST_TX) && grant_q[q]),
            .pending    (bus.q_tvalid[q]),
            .debit_en   (beat & grant_q[q]),
            .bytes      (beat_bytes),
            .idle_slope (cfg_idle_slope[q*SLOPE_WIDTH +: SLOPE_WIDTH]),
            .byte_cost  (cfg_byte_cost[q*SLOPE_WIDTH +: SLOPE_WIDTH]),
            .hi_credit  (cfg_hi_credit[q*CREDIT_WIDTH +: CREDIT_WIDTH]),
            .lo_credit  (cfg_lo_credit[q*CREDIT_WIDTH +: CREDIT_WIDTH]),
            .credit     (credit[q*CREDIT_WIDTH +: CREDIT_WIDTH])
        );
    end

    // Priority encoder: the highest eligible queue index wins.
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            if (elig[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    // Next state: grant on eligibility in IDLE, release on the tlast beat.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        gv_nxt    = gv_q;
        case (state)
            ST_IDLE: begin
                if ((|elig) && !bus.fifo_is_almost_full) begin
                    grant_nxt = sel;
                    gv_nxt    = 1'b1;
                    state_nxt = ST_TX;
                end
            end
            ST_TX: begin
                if (beat && bus.m_axis_tlast) begin
                    grant_nxt = '0;
                    gv_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // State and registered grant outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            gv_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            gv_q    <= gv_nxt;
        end
    end

`ifdef CBS_SCHED_STATS_EN
    // Per-queue frame counters, bumped on the accepted tlast beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_frames <= '0;
        end else begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                if (frame_end && grant_q[q]) begin
                    stat_frames[q*32 +: 32] <= stat_frames[q*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_cbs_frame_scheduler.sv
// Directed bench for cbs_frame_scheduler: reset, strict priority, CBS
// deficit and recovery, idle credit reset, clamping and back-pressure.
module tb_cbs_frame_scheduler;
    localparam int unsigned NQ = 8;
    localparam int unsigned CW = 32;
    localparam int unsigned SW = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic [NQ-1:0]    cfg_shaped_mask;
    logic [NQ*SW-1:0] cfg_idle_slope;
    logic [NQ*SW-1:0] cfg_byte_cost;
    logic [NQ*CW-1:0] cfg_hi_credit;
    logic [NQ*CW-1:0] cfg_lo_credit;
    logic [NQ*CW-1:0] credit;
`ifdef CBS_SCHED_STATS_EN
    logic [NQ*32-1:0] stat_frames;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int viol;
    int min_cr;

    cbs_frame_scheduler_if #(.NUM_QUEUES(NQ), .KEEP_WIDTH(1)) bus ();

    cbs_frame_scheduler #(
        .NUM_QUEUES   (NQ),
        .DATA_WIDTH   (8),
        .CREDIT_WIDTH (CW),
        .SLOPE_WIDTH  (SW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .cfg_shaped_mask (cfg_shaped_mask),
        .cfg_idle_slope  (cfg_idle_slope),
        .cfg_byte_cost   (cfg_byte_cost),
        .cfg_hi_credit   (cfg_hi_credit),
        .cfg_lo_credit   (cfg_lo_credit),
        .credit          (credit)
`ifdef CBS_SCHED_STATS_EN
        ,
        .stat_frames     (stat_frames)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [31:0] cr(input int q);
        return credit[q*CW +: CW];
    endfunction

    task automatic set_q(input int q, input logic shaped, input int slope, input int cost,
                         input int hi, input int lo);
        cfg_shaped_mask[q]        = shaped;
        cfg_idle_slope[q*SW +: SW] = slope[SW-1:0];
        cfg_byte_cost[q*SW +: SW]  = cost[SW-1:0];
        cfg_hi_credit[q*CW +: CW]  = hi;
        cfg_lo_credit[q*CW +: CW]  = lo;
    endtask

    initial begin
        rstn                    = 1'b0;
        bus.fifo_is_almost_full = 1'b0;
        bus.q_tvalid            = '0;
        bus.m_axis_tvalid       = 1'b0;
        bus.m_axis_tready       = 1'b1;
        bus.m_axis_tlast        = 1'b0;
        bus.m_axis_tkeep        = 1'b1;
        cfg_shaped_mask         = '0;
        cfg_idle_slope          = '0;
        cfg_byte_cost           = '0;
        for (int q = 0; q < NQ; q++) begin
            set_q(q, 1'b0, 0, 0, 32'h7fff_ffff, 32'h8000_0000);
        end

        // Reset state
        #1;
        check_eq("rst_grant", 64'(bus.grant), 64'h0);
        check_eq("rst_gv", 64'(bus.grant_valid), 64'h0);
        check_eq("rst_credit_nz", 64'(|credit), 64'h0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();

        // Strict priority, unshaped queues
        bus.q_tvalid = 8'h05;
        tick();
        check_eq("prio_first", 64'(bus.grant), 64'h04);
        check_eq("prio_gv", 64'(bus.grant_valid), 64'h1);
        bus.m_axis_tvalid = 1'b1; bus.m_axis_tlast = 1'b1; bus.q_tvalid = 8'h01;
        tick();
        check_eq("prio_gap_grant", 64'(bus.grant), 64'h0);
        check_eq("prio_gap_gv", 64'(bus.grant_valid), 64'h0);
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0;
        tick();
        check_eq("prio_second", 64'(bus.grant), 64'h01);
        bus.m_axis_tvalid = 1'b1; bus.m_axis_tlast = 1'b1; bus.q_tvalid = 8'h00;
        tick();
        check_eq("prio_end", 64'(bus.grant), 64'h0);
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0;

        // CBS deficit on q7: slope 1, cost 3, 64 one-byte beats.
        // Grant edge adds +1 (pending), each of 64 beats nets -2 -> -127.
        set_q(7, 1'b1, 1, 3, 32'h7fff_ffff, 32'h8000_0000);
        bus.q_tvalid = 8'h80;
        tick();
        check_eq("cbs_grant", 64'(bus.grant), 64'h80);
        check_eq("cbs_cr_grant", 64'(cr(7)), 64'(1));
        bus.m_axis_tvalid = 1'b1; bus.q_tvalid = 8'h81;
        repeat (63) tick();
        check_eq("cbs_cr_mid", 64'(cr(7)), 64'(-125));
        check_eq("cbs_hold", 64'(bus.grant), 64'h80);
        bus.m_axis_tlast = 1'b1;
        tick();
        check_eq("cbs_drop", 64'(bus.grant), 64'h0);
        check_eq("cbs_cr_end", 64'(cr(7)), 64'(-127));
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0;
        tick();
        check_eq("cbs_q0_grant", 64'(bus.grant), 64'h01);
        check_eq("cbs_cr_rec1", 64'(cr(7)), 64'(-126));
        bus.m_axis_tvalid = 1'b1; bus.m_axis_tlast = 1'b1; bus.q_tvalid = 8'h80;
        tick();
        check_eq("cbs_q0_end", 64'(bus.grant), 64'h0);
        check_eq("cbs_cr_nodebit", 64'(cr(7)), 64'(-125));
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0;
        viol = 0;
        for (int i = 0; i < 124; i++) begin
            tick();
            if (bus.grant != 8'h00) viol++;
        end
        check_eq("cbs_blocked", 64'(viol), 64'h0);
        check_eq("cbs_cr_m1", 64'(cr(7)), 64'(-1));
        tick();
        check_eq("cbs_cr_zero", 64'(cr(7)), 64'(0));
        check_eq("cbs_still_idle", 64'(bus.grant), 64'h0);
        tick();
        check_eq("cbs_regrant", 64'(bus.grant), 64'h80);
        bus.m_axis_tvalid = 1'b1; bus.m_axis_tlast = 1'b1; bus.q_tvalid = 8'h00;
        tick();
        check_eq("cbs_cr_neg_idle", 64'(cr(7)), 64'(-1));
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0;
        tick();
        check_eq("cbs_cr_recover", 64'(cr(7)), 64'(0));

        // Idle reset of positive credit on q3
        set_q(3, 1'b1, 50, 0, 32'h7fff_ffff, 32'h8000_0000);
        bus.fifo_is_almost_full = 1'b1; bus.q_tvalid = 8'h08;
        tick();
        check_eq("idle_cr50", 64'(cr(3)), 64'(50));
        check_eq("idle_fifo_block", 64'(bus.grant), 64'h0);
        bus.q_tvalid = 8'h00;
        tick();
        check_eq("idle_cr_zeroed", 64'(cr(3)), 64'(0));

        // Clamp on q5: hi 100, lo -200, slope 40, cost 100 per byte
        set_q(5, 1'b1, 40, 100, 100, -200);
        bus.q_tvalid = 8'h20;
        tick(); check_eq("clamp_40", 64'(cr(5)), 64'(40));
        tick(); check_eq("clamp_80", 64'(cr(5)), 64'(80));
        tick(); check_eq("clamp_100a", 64'(cr(5)), 64'(100));
        tick(); check_eq("clamp_100b", 64'(cr(5)), 64'(100));
        check_eq("clamp_blocked", 64'(bus.grant), 64'h0);
        bus.fifo_is_almost_full = 1'b0;
        tick();
        check_eq("clamp_grant", 64'(bus.grant), 64'h20);
        check_eq("clamp_hi_tx", 64'(cr(5)), 64'(100));
        bus.m_axis_tvalid = 1'b1;
        min_cr = 100;
        for (int i = 0; i < 1500; i++) begin
            bus.m_axis_tlast = (i == 1499);
            tick();
            if (cr(5) < min_cr) min_cr = cr(5);
        end
        check_eq("clamp_min", 64'(min_cr), 64'(-200));
        check_eq("clamp_lo_end", 64'(cr(5)), 64'(-200));
        check_eq("clamp_frame_done", 64'(bus.grant), 64'h0);
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0; bus.q_tvalid = 8'h00;
        repeat (5) tick();
        check_eq("clamp_recover", 64'(cr(5)), 64'(0));

        // Back-pressure on q6: slope 2, cost 5, 8 clks with 4 accepted beats
        set_q(6, 1'b1, 2, 5, 32'h7fff_ffff, 32'h8000_0000);
        bus.q_tvalid = 8'h40;
        tick();
        check_eq("bp_grant", 64'(bus.grant), 64'h40);
        check_eq("bp_cr_grant", 64'(cr(6)), 64'(2));
        bus.q_tvalid = 8'hC0;
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            bus.m_axis_tvalid       = 1'b1;
            bus.m_axis_tready       = (i % 2) == 1;
            bus.m_axis_tlast        = (i == 7);
            bus.fifo_is_almost_full = (i % 4) >= 2;
            tick();
            if (i < 7 && bus.grant != 8'h40) viol++;
        end
        check_eq("bp_hold", 64'(viol), 64'h0);
        check_eq("bp_cr_end", 64'(cr(6)), 64'(-2));
        check_eq("bp_release", 64'(bus.grant), 64'h0);
        bus.m_axis_tvalid = 1'b0; bus.m_axis_tlast = 1'b0;
        bus.fifo_is_almost_full = 1'b0; bus.m_axis_tready = 1'b1;
        tick();
        check_eq("bp_next_q7", 64'(bus.grant), 64'h80);

        // Asynchronous reset mid-frame
        #3;
        rstn = 1'b0;
        #1;
        check_eq("arst_grant", 64'(bus.grant), 64'h0);
        check_eq("arst_gv", 64'(bus.grant_valid), 64'h0);
        check_eq("arst_credit_nz", 64'(|credit), 64'h0);
        bus.q_tvalid = 8'h00;
        tick();
        rstn = 1'b1;
        tick();
        check_eq("arst_idle", 64'(bus.grant_valid), 64'h0);
        bus.q_tvalid = 8'h01;
        tick();
        check_eq("arst_regrant", 64'(bus.grant), 64'h01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
